// File: rtl/src2shift_pkg.sv
// -----------------------------------------------------------------------------
// src2shift_pkg
// Shared types and constants for the iterative operand-2 generator.
//   mode_t       : operation select presented on the mode port
//   state_t      : sequencer states (IDLE / SHIFT / DONE)
//   shift_kind_t : primitive shift performed by shift_step_unit
//   *_LSB/*_MSB  : field positions inside the 24-bit instruction immediate
// -----------------------------------------------------------------------------
package src2shift_pkg;

    typedef enum logic [3:0] {
        ROT_IMM8  = 4'd0,
        SH_LSL    = 4'd1,
        SH_LSR    = 4'd2,
        SH_ASR    = 4'd3,
        SH_ROR    = 4'd4,
        RS_LSL    = 4'd5,
        RS_LSR    = 4'd6,
        RS_ASR    = 4'd7,
        RS_ROR    = 4'd8,
        IMM12     = 4'd9,
        BR_IMM24  = 4'd10,
        RRX       = 4'd11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_LSL = 2'd0,
        K_LSR = 2'd1,
        K_ASR = 2'd2,
        K_ROR = 2'd3
    } shift_kind_t;

    // Immediate field positions within imm24.
    localparam int IMM8_LSB   = 0;
    localparam int IMM8_MSB   = 7;
    localparam int ROT_LSB    = 8;
    localparam int ROT_MSB    = 11;
    localparam int SHAMT5_LSB = 7;
    localparam int SHAMT5_MSB = 11;
    localparam int IMM12_MSB  = 11;

endpackage

// File: rtl/src2shift_pipe_shift_step_unit.sv
// -----------------------------------------------------------------------------
// shift_step_unit
// Combinational single-step shifter: shifts/rotates value_i by k_i bits
// (0 <= k_i <= STEP) and reports the last bit shifted out.
//   value_i : operand
//   kind_i  : LSL / LSR / ASR / ROR
//   k_i     : step size; 0 passes value_i and carry_i straight through
//   carry_i : carry to return when nothing is shifted
//   value_o : shifted result
//   carry_o : last bit shifted out (for ROR this equals the result MSB)
// -----------------------------------------------------------------------------
module shift_step_unit
    import src2shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value_i,
    input  shift_kind_t      kind_i,
    input  logic [KW-1:0]    k_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] value_o,
    output logic             carry_o
);

    // One candidate result per possible step size; index 0 is pass-through.
    logic [STEP:0][WIDTH-1:0] cand_val;
    logic [STEP:0]            cand_bit;

    assign cand_val[0] = value_i;
    assign cand_bit[0] = carry_i;

    genvar gi;
    generate
        for (gi = 1; gi <= STEP; gi++) begin : g_cand
            logic [WIDTH-1:0] lsl_v;
            logic [WIDTH-1:0] lsr_v;
            logic [WIDTH-1:0] asr_v;
            logic [WIDTH-1:0] ror_v;

            assign lsl_v = value_i << gi;
            assign lsr_v = value_i >> gi;
            assign asr_v = $unsigned($signed(value_i) >>> gi);
            // Written as two shifts so gi == WIDTH stays legal.
            assign ror_v = (value_i >> gi) | (value_i << (WIDTH - gi));

            assign cand_val[gi] = (kind_i == K_LSL) ? lsl_v :
                                  (kind_i == K_LSR) ? lsr_v :
                                  (kind_i == K_ASR) ? asr_v : ror_v;
            // Left shift loses the top bits; every right-going kind loses
            // the bottom bits, and for ROR bit gi-1 becomes the new MSB.
            assign cand_bit[gi] = (kind_i == K_LSL) ? value_i[WIDTH-gi]
                                                    : value_i[gi-1];
        end
    endgenerate

    always_comb begin
        value_o = cand_val[0];
        carry_o = cand_bit[0];
        for (int i = 1; i <= STEP; i++) begin
            if (k_i == KW'(i)) begin
                value_o = cand_val[i];
                carry_o = cand_bit[i];
            end
        end
    end

endmodule

// File: rtl/src2shift_pipe.sv
// -----------------------------------------------------------------------------
// src2shift_pipe
// Iterative operand-2 generator. Accepts one request per handshake, resolves
// all ARM boundary cases at capture, then shifts/rotates up to STEP bits per
// clock until the effective amount is exhausted.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake (ready only when idle)
//   mode                : src2shift_pkg::mode_t operation select
//   rm, rs_amt, imm24   : operands (Rm, Rs[AMT_W-1:0], instruction[23:0])
//   carry_in            : current C flag
//   out_valid/out_ready : result handshake
//   src2, carry_out     : registered result, held while out_ready is low
// The capture edge already performs the first step, so a request with
// effective amount n presents its result max(1, ceil(n/STEP)) edges after
// it is accepted (counting the accept edge).
// -----------------------------------------------------------------------------
module src2shift_pipe
    import src2shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       mode,
    input  logic [WIDTH-1:0] rm,
    input  logic [AMT_W-1:0] rs_amt,
    input  logic [23:0]      imm24,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] src2,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int KW    = $clog2(STEP + 1);
    localparam int LOG_W = $clog2(WIDTH);
    localparam int CMP_W = (AMT_W > CNT_W) ? AMT_W : CNT_W;
    localparam logic [CMP_W-1:0] W_CMP    = CMP_W'(WIDTH);
    localparam logic [CNT_W-1:0] W_CNT    = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(STEP);

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t           state_q;
    logic [WIDTH-1:0] val_q;
    logic             carry_q;
    logic [CNT_W-1:0] rem_q;
    shift_kind_t      kind_q;
    logic             in_ready_q;
    logic             out_valid_q;

    // ---------------------------------------------------------------------
    // Capture decode: initial value, carry, kind and effective amount n.
    // Every special case that needs no shifting is settled here with n=0.
    // ---------------------------------------------------------------------
    mode_t            mode_s;
    logic [4:0]       shamt5;
    logic [3:0]       rot4;
    logic [CMP_W-1:0] rs_cmp;
    logic [LOG_W-1:0] rs_mod;

    logic [WIDTH-1:0] cap_val;
    logic             cap_carry;
    logic [CNT_W-1:0] cap_n;
    shift_kind_t      cap_kind;

    assign mode_s = mode_t'(mode);
    assign shamt5 = imm24[SHAMT5_MSB:SHAMT5_LSB];
    assign rot4   = imm24[ROT_MSB:ROT_LSB];
    assign rs_cmp = CMP_W'(rs_amt);
    assign rs_mod = rs_cmp[LOG_W-1:0];

    always_comb begin
        cap_val   = rm;
        cap_carry = carry_in;
        cap_n     = '0;
        cap_kind  = K_LSL;
        case (mode_s)
            ROT_IMM8: begin
                cap_val  = {{(WIDTH-8){1'b0}}, imm24[IMM8_MSB:IMM8_LSB]};
                cap_kind = K_ROR;
                cap_n    = CNT_W'({rot4, 1'b0});
            end
            SH_LSL: begin
                cap_kind = K_LSL;
                cap_n    = CNT_W'(shamt5);
            end
            SH_LSR, SH_ASR: begin
                // A zero immediate amount encodes a full-width shift.
                cap_kind = (mode_s == SH_LSR) ? K_LSR : K_ASR;
                cap_n    = (shamt5 == 5'd0) ? W_CNT : CNT_W'(shamt5);
            end
            SH_ROR: begin
                if (shamt5 == 5'd0) begin
                    cap_val   = {carry_in, rm[WIDTH-1:1]};
                    cap_carry = rm[0];
                end else begin
                    cap_kind = K_ROR;
                    cap_n    = CNT_W'(shamt5);
                end
            end
            RRX: begin
                cap_val   = {carry_in, rm[WIDTH-1:1]};
                cap_carry = rm[0];
            end
            RS_LSL, RS_LSR: begin
                if (rs_cmp > W_CMP) begin
                    cap_val   = '0;
                    cap_carry = 1'b0;
                end else begin
                    cap_kind = (mode_s == RS_LSL) ? K_LSL : K_LSR;
                    cap_n    = CNT_W'(rs_cmp);
                end
            end
            RS_ASR: begin
                cap_kind = K_ASR;
                cap_n    = (rs_cmp >= W_CMP) ? W_CNT : CNT_W'(rs_cmp);
            end
            RS_ROR: begin
                if (rs_cmp != '0) begin
                    if (rs_mod == '0) begin
                        cap_carry = rm[WIDTH-1];
                    end else begin
                        cap_kind = K_ROR;
                        cap_n    = CNT_W'(rs_mod);
                    end
                end
            end
            IMM12: begin
                cap_val = {{(WIDTH-12){1'b0}}, imm24[IMM12_MSB:0]};
            end
            BR_IMM24: begin
                cap_val = {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};
            end
            default: begin
                cap_val = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Step datapath: in IDLE it works on the freshly decoded request, in
    // SHIFT on the in-flight registers.
    // ---------------------------------------------------------------------
    logic             busy;
    logic [WIDTH-1:0] stp_val;
    logic             stp_carry;
    logic [CNT_W-1:0] stp_rem;
    shift_kind_t      stp_kind;
    logic [KW-1:0]    k_sel;

    logic [WIDTH-1:0] val_d;
    logic             carry_d;
    logic [CNT_W-1:0] rem_d;

    assign busy      = (state_q == SHIFT);
    assign stp_val   = busy ? val_q   : cap_val;
    assign stp_carry = busy ? carry_q : cap_carry;
    assign stp_rem   = busy ? rem_q   : cap_n;
    assign stp_kind  = busy ? kind_q  : cap_kind;
    assign k_sel     = (stp_rem >= STEP_CNT) ? KW'(STEP) : KW'(stp_rem);
    assign rem_d     = stp_rem - CNT_W'(k_sel);

    shift_step_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .value_i (stp_val),
        .kind_i  (stp_kind),
        .k_i     (k_sel),
        .carry_i (stp_carry),
        .value_o (val_d),
        .carry_o (carry_d)
    );

    // ---------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            val_q       <= '0;
            carry_q     <= 1'b0;
            rem_q       <= '0;
            kind_q      <= K_LSL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        val_q      <= val_d;
                        carry_q    <= carry_d;
                        rem_q      <= rem_d;
                        kind_q     <= cap_kind;
                        in_ready_q <= 1'b0;
                        if (rem_d != '0) begin
                            state_q <= SHIFT;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    val_q   <= val_d;
                    carry_q <= carry_d;
                    rem_q   <= rem_d;
                    if (rem_d == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // A request arriving on the retire edge is not taken:
                    // in_ready is still low during this cycle.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign src2      = val_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_src2shift_pipe.sv
module tb_src2shift_pipe;
    import src2shift_pkg::*;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;
    localparam int AMT_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        mode;
    logic [WIDTH-1:0]  rm;
    logic [AMT_W-1:0]  rs_amt;
    logic [23:0]       imm24;
    logic              carry_in;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  src2;
    logic              carry_out;

    always #5 clk = ~clk;

    src2shift_pipe #(.WIDTH(WIDTH), .STEP(STEP), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .rm        (rm),
        .rs_amt    (rs_amt),
        .imm24     (imm24),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .src2      (src2),
        .carry_out (carry_out)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  mode;
        logic [31:0] rm;
        logic [7:0]  rs;
        logic [23:0] imm;
        logic        cin;
        logic [31:0] exp_src2;
        logic        exp_c;
        int          exp_lat;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // ---- Reference model: ARM shifter rules in plain 64-bit arithmetic ----
    function automatic logic [32:0] m_lsl(input logic [31:0] v, input int n);
        logic [63:0] t;
        t = {32'd0, v} << n;
        return {t[32], t[31:0]};
    endfunction

    function automatic logic [32:0] m_lsr(input logic [31:0] v, input int n);
        logic [63:0] t;
        t = {v, 32'd0} >> n;
        return {t[31], t[63:32]};
    endfunction

    function automatic logic [32:0] m_asr(input logic [31:0] v, input int n);
        logic [63:0] t;
        t = $unsigned($signed({v, 32'd0}) >>> n);
        return {t[31], t[63:32]};
    endfunction

    function automatic logic [32:0] m_ror(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = (v >> n) | (v << (32 - n));
        return {r[31], r};
    endfunction

    task automatic ref_model(input logic [3:0] m, input logic [31:0] r, input logic [7:0] s,
                             input logic [23:0] i, input logic c,
                             output logic [31:0] e_src2, output logic e_c, output int e_lat);
        logic [32:0] res;
        int n;
        int sh;
        int rot;
        int rsv;
        n   = 0;
        sh  = int'(i[11:7]);
        rot = 2 * int'(i[11:8]);
        rsv = int'(s);
        case (m)
            4'd0: begin
                if (rot == 0) res = {c, 24'd0, i[7:0]};
                else begin res = m_ror({24'd0, i[7:0]}, rot); n = rot; end
            end
            4'd1: begin
                if (sh == 0) res = {c, r};
                else begin res = m_lsl(r, sh); n = sh; end
            end
            4'd2: begin n = (sh == 0) ? 32 : sh; res = m_lsr(r, n); end
            4'd3: begin n = (sh == 0) ? 32 : sh; res = m_asr(r, n); end
            4'd4: begin
                if (sh == 0) res = {r[0], c, r[31:1]};
                else begin res = m_ror(r, sh); n = sh; end
            end
            4'd5: begin
                if (rsv == 0) res = {c, r};
                else if (rsv <= 32) begin res = m_lsl(r, rsv); n = rsv; end
                else res = 33'd0;
            end
            4'd6: begin
                if (rsv == 0) res = {c, r};
                else if (rsv <= 32) begin res = m_lsr(r, rsv); n = rsv; end
                else res = 33'd0;
            end
            4'd7: begin
                if (rsv == 0) res = {c, r};
                else begin n = (rsv > 32) ? 32 : rsv; res = m_asr(r, n); end
            end
            4'd8: begin
                if (rsv == 0) res = {c, r};
                else if (rsv % 32 == 0) res = {r[31], r};
                else begin n = rsv % 32; res = m_ror(r, n); end
            end
            4'd9:  res = {c, 20'd0, i[11:0]};
            4'd10: res = {c, {6{i[23]}}, i, 2'b00};
            4'd11: res = {r[0], c, r[31:1]};
            default: res = {c, 32'd0};
        endcase
        e_src2 = res[31:0];
        e_c    = res[32];
        e_lat  = (n == 0) ? 1 : (n + STEP - 1) / STEP;
    endtask

    // One complete request: handshake in, count edges to out_valid, retire.
    task automatic run_req(input logic [3:0] m, input logic [31:0] r, input logic [7:0] s,
                           input logic [23:0] i, input logic c,
                           output logic [31:0] got, output logic gc, output int lat);
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        mode = m; rm = r; rs_amt = s; imm24 = i; carry_in = c;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        got = src2;
        gc  = carry_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        logic        gc;
        int          lat;
        logic [31:0] e_src2;
        logic        e_c;
        int          e_lat;
        logic [31:0] held;
        logic        held_c;
        logic [3:0]  rmode;
        logic [7:0]  rrs;
        int          waited;

        //           mode   rm            rs     imm           cin   src2          C     lat
        vecs[0]  = '{4'd0,  32'h00000000, 8'd0,   24'h0002FF, 1'b0, 32'hF000000F, 1'b1, 1};
        vecs[1]  = '{4'd1,  32'h80000001, 8'd0,   24'h000080, 1'b0, 32'h00000002, 1'b1, 1};
        vecs[2]  = '{4'd1,  32'h80000001, 8'd0,   24'h000000, 1'b1, 32'h80000001, 1'b1, 1};
        vecs[3]  = '{4'd6,  32'h80000000, 8'd32,  24'h000000, 1'b0, 32'h00000000, 1'b1, 8};
        vecs[4]  = '{4'd6,  32'h80000000, 8'd33,  24'h000000, 1'b0, 32'h00000000, 1'b0, 1};
        vecs[5]  = '{4'd3,  32'h80000000, 8'd0,   24'h000000, 1'b0, 32'hFFFFFFFF, 1'b1, 8};
        vecs[6]  = '{4'd8,  32'h0000000F, 8'd36,  24'h000000, 1'b0, 32'hF0000000, 1'b1, 1};
        vecs[7]  = '{4'd11, 32'h00000003, 8'd0,   24'h000000, 1'b1, 32'h80000001, 1'b1, 1};
        vecs[8]  = '{4'd10, 32'h00000000, 8'd0,   24'hFFFFFF, 1'b0, 32'hFFFFFFFC, 1'b0, 1};
        vecs[9]  = '{4'd9,  32'h00000000, 8'd0,   24'hABC123, 1'b1, 32'h00000123, 1'b1, 1};
        vecs[10] = '{4'd5,  32'h00000001, 8'd32,  24'h000000, 1'b0, 32'h00000000, 1'b1, 8};
        vecs[11] = '{4'd5,  32'h00000001, 8'd40,  24'h000000, 1'b1, 32'h00000000, 1'b0, 1};
        vecs[12] = '{4'd4,  32'h80000001, 8'd0,   24'h000000, 1'b0, 32'h40000000, 1'b1, 1};
        vecs[13] = '{4'd8,  32'h80000001, 8'd64,  24'h000000, 1'b0, 32'h80000001, 1'b1, 1};
        vecs[14] = '{4'd7,  32'h40000000, 8'd200, 24'h000000, 1'b1, 32'h00000000, 1'b0, 8};
        vecs[15] = '{4'd13, 32'h12345678, 8'd0,   24'h000000, 1'b1, 32'h00000000, 1'b1, 1};
        vecs[16] = '{4'd0,  32'h00000000, 8'd0,   24'h0000AB, 1'b1, 32'h000000AB, 1'b1, 1};
        vecs[17] = '{4'd2,  32'h000000F0, 8'd0,   24'h000280, 1'b0, 32'h00000007, 1'b1, 2};

        // ---- Reset state ----
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        mode = '0; rm = '0; rs_amt = '0; imm24 = '0; carry_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_src2", 64'(src2), 64'd0);
        chk("rst_carry", 64'(carry_out), 64'd0);
        reset = 1'b0;

        // ---- Directed vector table ----
        for (int v = 0; v < 18; v++) begin
            run_req(vecs[v].mode, vecs[v].rm, vecs[v].rs, vecs[v].imm, vecs[v].cin, got, gc, lat);
            $display("vec %0d mode=%0d src2=%h c=%b lat=%0d", v, vecs[v].mode, got, gc, lat);
            chk($sformatf("vec%0d_src2", v), 64'(got), 64'(vecs[v].exp_src2));
            chk($sformatf("vec%0d_carry", v), 64'(gc), 64'(vecs[v].exp_c));
            chk($sformatf("vec%0d_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
        end

        // ---- Hold in DONE with out_ready low; busy in_valid ignored ----
        ref_model(4'd6, 32'hDEADBEEF, 8'd20, 24'h0, 1'b0, e_src2, e_c, e_lat);
        @(negedge clk);
        mode = 4'd6; rm = 32'hDEADBEEF; rs_amt = 8'd20; imm24 = '0; carry_in = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        // A second request held on the port while busy must not be latched.
        mode = 4'd9; imm24 = 24'h000555; carry_in = 1'b1;
        waited = 1;
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("hold_lat", 64'(waited), 64'(e_lat));
        held = src2; held_c = carry_out;
        $display("hold mode=6 src2=%h c=%b lat=%0d", held, held_c, waited);
        chk("hold_src2", 64'(held), 64'(e_src2));
        chk("hold_carry", 64'(held_c), 64'(e_c));
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_src2", h), 64'(src2), 64'(e_src2));
            chk($sformatf("hold%0d_carry", h), 64'(carry_out), 64'(e_c));
            chk($sformatf("hold%0d_in_ready", h), 64'(in_ready), 64'd0);
            chk($sformatf("hold%0d_out_valid", h), 64'(out_valid), 64'd1);
        end
        // Retire with in_valid still high: the new request must not be taken.
        out_ready = 1'b1;
        @(negedge clk);
        chk("retire_out_valid", 64'(out_valid), 64'd0);
        chk("retire_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0; out_ready = 1'b0;

        // ---- Reset in the middle of a long shift ----
        @(negedge clk);
        mode = 4'd3; rm = 32'h80000000; imm24 = '0; carry_in = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midshift_busy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("midreset out_valid=%b in_ready=%b src2=%h", out_valid, in_ready, src2);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_src2", 64'(src2), 64'd0);
        chk("midrst_carry", 64'(carry_out), 64'd0);
        repeat (10) @(negedge clk);
        chk("midrst_discarded", 64'(out_valid), 64'd0);

        // ---- Randomized requests against the reference model ----
        for (int t = 0; t < 150; t++) begin
            rmode = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: rrs = 8'd0;
                1: rrs = 8'd32;
                2: rrs = 8'd33;
                3: rrs = 8'd64;
                default: rrs = 8'($urandom_range(0, 255));
            endcase
            rm       = $urandom;
            imm24    = 24'($urandom);
            carry_in = 1'($urandom_range(0, 1));
            ref_model(rmode, rm, rrs, imm24, carry_in, e_src2, e_c, e_lat);
            run_req(rmode, rm, rrs, imm24, carry_in, got, gc, lat);
            $display("rnd %0d mode=%0d rs=%0d src2=%h c=%b lat=%0d", t, rmode, rrs, got, gc, lat);
            chk($sformatf("rnd%0d_src2", t), 64'(got), 64'(e_src2));
            chk($sformatf("rnd%0d_carry", t), 64'(gc), 64'(e_c));
            chk($sformatf("rnd%0d_lat", t), 64'(lat), 64'(e_lat));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
